// File: rtl/pipelined_alu_if.sv
// Request/response bundle for pipelined_alu.
// The master drives requests and consumes results; the slave is the ALU itself.
interface pipelined_alu_if #(
  parameter int WIDTH = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   rs;
  logic [WIDTH-1:0]   rt;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   rd;
  logic               carry;
  logic               zero;

  modport master (
    output in_valid, sel, rs, rt, shamt, out_ready,
    input  in_ready, out_valid, rd, carry, zero
  );

  modport slave (
    input  in_valid, sel, rs, rt, shamt, out_ready,
    output in_ready, out_valid, rd, carry, zero
  );
endinterface

// File: rtl/pipelined_alu.sv
// Small ALU with valid/ready on both sides.
// Most opcodes finish in one cycle; ASR and ROL with a non-zero distance walk
// through a SHIFT state doing one single-bit step per cycle.
module pipelined_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_alu_if.slave   bus,
  output logic             busy
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               rol_q, rol_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               is_multi;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   step;

  assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.rd        = rd_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign busy          = (state_q == SHIFT);

  // Single-cycle result for the current request; shift ops with distance 0 pass the operand through.
  always_comb begin
    sum_ext   = {1'b0, bus.rs} + {1'b0, bus.rt};
    diff_ext  = {1'b0, bus.rs} - {1'b0, bus.rt};
    alu_res   = '0;
    alu_carry = 1'b0;
    is_multi  = ((bus.sel == OP_ASR) || (bus.sel == OP_ROL)) && (bus.shamt != '0);
    case (bus.sel)
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_AND: alu_res = bus.rs & bus.rt;
      OP_OR:  alu_res = bus.rs | bus.rt;
      OP_ASR: alu_res = bus.rt;
      OP_ROL: alu_res = bus.rs;
      OP_LT:  alu_res = {{(WIDTH-2){1'b1}}, 1'b0, (bus.rs < bus.rt)};
      OP_EQ:  alu_res = {{(WIDTH-1){1'b1}}, (bus.rs == bus.rt)};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, step the shifter in SHIFT, and retire results.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    rol_d       = rol_q;
    rd_d        = rd_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    step        = rol_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                        : {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_multi) begin
            state_d = SHIFT;
            cnt_d   = bus.shamt;
            work_d  = (bus.sel == OP_ASR) ? bus.rt : bus.rs;
            rol_d   = (bus.sel == OP_ROL);
          end else begin
            rd_d        = alu_res;
            carry_d     = alu_carry;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        cnt_d  = cnt_q - SHAMT_W'(1);
        work_d = step;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d     = IDLE;
          rd_d        = step;
          carry_d     = 1'b0;
          zero_d      = (step == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any shift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      rol_q       <= 1'b0;
      rd_q        <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      rol_q       <= rol_d;
      rd_q        <= rd_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu at WIDTH=4.
// Accepted requests push a modelled result; results leaving the DUT are compared in order.
module tb_pipelined_alu;
  localparam int WIDTH = 4;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [3:0] rd;
    logic       carry;
    logic       zero;
  } result_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    busy;
  int      compare_count = 0;
  int      mismatch_count = 0;
  bit      random_phase = 1'b0;
  logic    prev_hold = 1'b0;
  result_t expected_q[$];
  int      waits;

  pipelined_alu_if #(.WIDTH(WIDTH)) bus ();

  pipelined_alu #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic result_t modelAlu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] sh);
    result_t r;
    int tmp;
    int k;
    logic signed [3:0] sb;
    r   = '0;
    tmp = 0;
    sb  = b;
    case (op)
      OP_SUB: begin
        r.rd    = a - b;
        r.carry = (a < b);
      end
      OP_ADD: begin
        tmp     = int'(a) + int'(b);
        r.rd    = tmp[3:0];
        r.carry = (tmp > 15);
      end
      OP_AND: r.rd = a & b;
      OP_OR:  r.rd = a | b;
      OP_ASR: r.rd = sb >>> sh;
      OP_ROL: begin
        k    = int'(sh) % WIDTH;
        tmp  = (int'(a) << k) | (int'(a) >> (WIDTH - k));
        r.rd = tmp[3:0];
      end
      OP_LT:  r.rd = {2'b11, 1'b0, (a < b)};
      default: r.rd = {3'b111, (a == b)};
    endcase
    r.zero = (r.rd == 4'd0);
    return r;
  endfunction

  // Scoreboard: compare whatever the DUT presents against the oldest outstanding request, then record new acceptances.
  always @(negedge clk) begin
    result_t exp_r;
    if (rst_n) begin
      if (prev_hold) checkOutput("hold_out_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (expected_q.size() == 0) begin
          checkOutput("unexpected_out", 1, 0);
        end else begin
          exp_r = expected_q[0];
          checkOutput(bus.out_ready ? "rd" : "held_rd", bus.rd, exp_r.rd);
          checkOutput(bus.out_ready ? "carry" : "held_carry", bus.carry, exp_r.carry);
          checkOutput(bus.out_ready ? "zero" : "held_zero", bus.zero, exp_r.zero);
          if (bus.out_ready) void'(expected_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        expected_q.push_back(modelAlu(bus.sel, bus.rs, bus.rt, bus.shamt));
      prev_hold <= bus.out_valid && !bus.out_ready;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  // Random backpressure during the random phase, changed well away from both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (random_phase) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one request and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] sh, output int wait_cycles);
    bit done;
    done        = 1'b0;
    wait_cycles = 0;
    bus.sel      = op;
    bus.rs       = a;
    bus.rt       = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        wait_cycles++;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  // After a shift request is accepted, confirm the busy window and the cycle the result appears.
  task automatic checkShiftTiming(input string tag, input int steps, input logic [3:0] exp_rd);
    for (int i = 0; i < steps; i++) begin
      checkOutput({tag, "_busy"}, busy, 1);
      checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
      checkOutput({tag, "_early_valid"}, bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_busy_done"}, busy, 0);
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_rd"}, bus.rd, exp_rd);
  endtask

  initial begin
    int stray;
    logic [2:0] op;
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    #12;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_rd", bus.rd, 0);
    checkOutput("reset_carry", bus.carry, 0);
    checkOutput("reset_zero", bus.zero, 0);
    checkOutput("reset_busy", busy, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(OP_SUB, 4'd15, 4'd12, 2'd0, waits);
    checkOutput("first_accept_wait", waits, 0);
    checkOutput("sub_latency_valid", bus.out_valid, 1);
    checkOutput("sub_rd_direct", bus.rd, 4'b0011);

    applyStimulus(OP_SUB, 4'd4, 4'd6, 2'd0, waits);
    checkOutput("sub_borrow_direct", bus.carry, 1);
    applyStimulus(OP_ADD, 4'd13, 4'd2, 2'd0, waits);
    applyStimulus(OP_ADD, 4'd15, 4'd1, 2'd0, waits);
    checkOutput("add_wrap_zero_direct", bus.zero, 1);
    applyStimulus(OP_LT, 4'd2, 4'd4, 2'd0, waits);
    applyStimulus(OP_LT, 4'd6, 4'd4, 2'd0, waits);
    applyStimulus(OP_EQ, 4'd6, 4'd6, 2'd0, waits);
    applyStimulus(OP_EQ, 4'd6, 4'd7, 2'd0, waits);
    checkOutput("eq_false_direct", bus.rd, 4'b1110);

    applyStimulus(OP_ASR, 4'd0, 4'b1000, 2'd1, waits);
    checkShiftTiming("asr", 1, 4'b1100);
    applyStimulus(OP_ROL, 4'b1001, 4'd0, 2'd3, waits);
    checkShiftTiming("rol", 3, 4'b1100);
    applyStimulus(OP_ASR, 4'd0, 4'b0110, 2'd0, waits);
    checkOutput("asr_zero_dist_valid", bus.out_valid, 1);

    applyStimulus(OP_AND, 4'd12, 4'd10, 2'd0, waits);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", bus.out_valid, 1);
      checkOutput("bp_rd", bus.rd, 4'b1000);
      checkOutput("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    applyStimulus(OP_OR, 4'd5, 4'd2, 2'd0, waits);
    checkOutput("b2b_wait", waits, 0);
    checkOutput("b2b_out_valid", bus.out_valid, 1);
    checkOutput("b2b_rd", bus.rd, 4'b0111);

    applyStimulus(OP_ROL, 4'b1001, 4'd0, 2'd3, waits);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", bus.out_valid, 0);
    checkOutput("rst_mid_rd", bus.rd, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_in_ready", bus.in_ready, 1);
    expected_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    checkOutput("no_result_after_reset", stray, 0);

    @(posedge clk);
    #1;
    random_phase = 1'b1;
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      applyStimulus(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), waits);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    random_phase = 1'b0;
    @(posedge clk);
    #3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && expected_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_empty", expected_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end
endmodule
